// File: rtl/m_minmax_decimator.sv
// Min/max decimator: folds N ADC samples into one (MIN, MAX, CLIP) pair.
// Optional MINMAX_CONNECT_EN seeds each window with the previous last sample.
module m_minmax_decimator #(
  parameter int WIDTH      = 8,
  parameter int RATIO_BITS = 8
) (
  input  logic                  CLK_ADC,
  input  logic                  RST_N,
  input  logic [WIDTH-1:0]      SAMPLE,
  input  logic                  SAMPLE_VALID,
  input  logic [RATIO_BITS-1:0] RATIO,
  input  logic                  RESTART,
  output logic [WIDTH-1:0]      MIN,
  output logic [WIDTH-1:0]      MAX,
  output logic                  CLIP,
  output logic                  OUT_VALID
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [RATIO_BITS-1:0] count;
  logic [RATIO_BITS-1:0] n_lat;
  logic [WIDTH-1:0]      acc_min;
  logic [WIDTH-1:0]      acc_max;
  logic                  acc_clip;

  logic                  first;
  logic [RATIO_BITS-1:0] n_new;
  logic [RATIO_BITS-1:0] n_eff;
  logic [RATIO_BITS-1:0] b_count;
  logic [RATIO_BITS:0]   cnt_inc;
  logic [WIDTH-1:0]      b_min;
  logic [WIDTH-1:0]      b_max;
  logic                  b_clip;
  logic [WIDTH-1:0]      s_min;
  logic [WIDTH-1:0]      s_max;
  logic                  s_clip;
  logic                  is_last;
  logic                  emit;
  logic [WIDTH-1:0]      seed_min;
  logic [WIDTH-1:0]      seed_max;

  always_comb begin
    first   = RESTART || (count == '0);
    n_new   = (RATIO == '0) ? {{(RATIO_BITS-1){1'b0}}, 1'b1} : RATIO;
    n_eff   = first ? n_new : n_lat;
    b_count = RESTART ? '0 : count;
    b_min   = RESTART ? ONES : acc_min;
    b_max   = RESTART ? '0 : acc_max;
    b_clip  = RESTART ? 1'b0 : acc_clip;
    s_min   = (SAMPLE < b_min) ? SAMPLE : b_min;
    s_max   = (SAMPLE > b_max) ? SAMPLE : b_max;
    s_clip  = b_clip || (SAMPLE == '0) || (SAMPLE == ONES);
    // extra bit so N = 2^RATIO_BITS-1 compares without wrap
    cnt_inc = {1'b0, b_count} + 1'b1;
    is_last = (cnt_inc == {1'b0, n_eff});
    emit    = SAMPLE_VALID && is_last && !RESTART;
`ifdef MINMAX_CONNECT_EN
    seed_min = SAMPLE;
    seed_max = SAMPLE;
`else
    seed_min = ONES;
    seed_max = '0;
`endif
  end

  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      count     <= '0;
      n_lat     <= {{(RATIO_BITS-1){1'b0}}, 1'b1};
      acc_min   <= ONES;
      acc_max   <= '0;
      acc_clip  <= 1'b0;
      MIN       <= '0;
      MAX       <= '0;
      CLIP      <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= emit;
      if (SAMPLE_VALID) begin
        if (first) n_lat <= n_eff;
        if (emit) begin
          MIN      <= s_min;
          MAX      <= s_max;
          CLIP     <= s_clip;
          count    <= '0;
          acc_min  <= seed_min;
          acc_max  <= seed_max;
          acc_clip <= 1'b0;
        end else if (is_last) begin
          // last sample swallowed by RESTART: start clean
          count    <= '0;
          acc_min  <= ONES;
          acc_max  <= '0;
          acc_clip <= 1'b0;
        end else begin
          count    <= cnt_inc[RATIO_BITS-1:0];
          acc_min  <= s_min;
          acc_max  <= s_max;
          acc_clip <= s_clip;
        end
      end else if (RESTART) begin
        count    <= '0;
        acc_min  <= ONES;
        acc_max  <= '0;
        acc_clip <= 1'b0;
      end
    end
  end

endmodule

// File: doc/m_minmax_decimator.md
Name: m_minmax_decimator

Overview:
- Front-end producer of min/max sample pairs for the capture buffer, in the ADC clock domain.
- Reduces raw ADC samples over a programmable window of N samples to one (MIN, MAX) pair plus a one-cycle strobe.
- MIN/MAX drive the buffer's D (min) and E (max) inputs; one pair per displayed column at slow timebases.

Parameters:
- WIDTH, 8, sample and min/max bit width.
- RATIO_BITS, 8, width of the RATIO input and the internal window counter.

Ports:
- CLK_ADC  input  1  ADC sample clock, rising edge; the only clock.
- RST_N  input  1  asynchronous active-low reset.
- SAMPLE  input  WIDTH  raw ADC sample.
- SAMPLE_VALID  input  1  SAMPLE is qualified this cycle.
- RATIO  input  RATIO_BITS  window length N in samples; 0 is treated as 1.
- RESTART  input  1  synchronous; discards the partial window.
- MIN  output  WIDTH  minimum of the last completed window.
- MAX  output  WIDTH  maximum of the last completed window.
- CLIP  output  1  last completed window contained a sample equal to 0 or to all-ones.
- OUT_VALID  output  1  one-cycle strobe; MIN/MAX/CLIP updated this cycle.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Outputs: MIN=0, MAX=0, CLIP=0, OUT_VALID=0.
  - Internal: count=0, acc_min=all-ones, acc_max=0, acc_clip=0, n_lat=1.
- Window start: on a valid sample with count==0, latch n_lat=max(RATIO,1).
  - A RATIO change mid-window takes effect only at the next window start.
- Valid sample, not last (count+1 < n_lat):
  - acc_min=min(acc_min,SAMPLE), acc_max=max(acc_max,SAMPLE), acc_clip |= (SAMPLE==0 or SAMPLE==all-ones).
  - count increments.
- Valid sample, last (count+1 == n_lat):
  - Next edge: MIN/MAX/CLIP take the accumulated values including this sample; OUT_VALID=1.
  - count=0; accumulators reinitialise (acc_min=all-ones, acc_max=0, acc_clip=0).
  - Latency: exactly one CLK_ADC from the last sample to OUT_VALID.
- SAMPLE_VALID low: no state change; OUT_VALID low the following cycle.
- OUT_VALID is high for exactly one cycle per window, never two cycles in a row unless N=1 with back-to-back valid samples.
- N=1: every valid sample produces a pair with MIN=MAX=SAMPLE.
- MIN/MAX/CLIP hold their values between strobes.
- Guarantee: MIN <= MAX in every emitted pair.
- RESTART high:
  - Accumulators and count reinitialise; no OUT_VALID for the discarded window.
  - If SAMPLE_VALID is high in the same cycle, that sample becomes sample 1 of a fresh window, with RATIO latched that cycle.
  - RESTART has priority over window completion: a last sample coinciding with RESTART emits nothing.
- Counter width: count is RATIO_BITS wide. N = 2^RATIO_BITS - 1 is the maximum and must complete without wrap.
- Reset mid-window: the partial window is lost and outputs return to reset values immediately.

Optional Feature:
- Macro: MINMAX_CONNECT_EN.
- Defined:
  - The last sample of each completed window is stored (last_s).
  - Each new window seeds acc_min=acc_max=last_s instead of all-ones/0, so consecutive columns overlap and the displayed trace has no vertical gaps.
  - last_s is invalid after reset or RESTART; the first window then uses normal seeding.
- Not defined: plain seeding; no extra registers.

Test Plan:
- RATIO=4, samples 10,50,20,30 -> one cycle after sample 30: OUT_VALID=1, MIN=10, MAX=50, CLIP=0; OUT_VALID=0 on the next cycle.
- RATIO=0, samples 7,9 back-to-back -> two consecutive strobes: (7,7) then (9,9).
- RATIO=3, samples 5,(gap of 3 invalid cycles),255,6 -> strobe one cycle after 6: MIN=5, MAX=255, CLIP=1.
- RATIO=4, samples 1,2, then RESTART concurrent with sample 100, then 101,102,103 -> no strobe for 1,2; next strobe MIN=100, MAX=103.
- RATIO=2, samples 40,41; RATIO changed to 3 during sample 41; then 42,43,44 -> strobes (40,41) then (42,44).
- With MINMAX_CONNECT_EN defined, RATIO=2, samples 10,20,80,90 -> strobes (10,20) then (20,90). Without the macro -> (10,20) then (80,90). RST_N pulse mid-window -> MIN=MAX=0, OUT_VALID=0 immediately.
